// File: rtl/clk_gate_sched_pkg.sv
// clk_gate_sched_pkg: shared channel state encoding and register offsets for clk_gate_sched
package clk_gate_sched_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      WAKE = 2'd1,
      ON   = 2'd2,
      IDLE = 2'd3
   } ch_state_t;

   localparam logic [4:0] REG_SWEN     = 5'h00;
   localparam logic [4:0] REG_AUTO     = 5'h04;
   localparam logic [4:0] REG_TMO      = 5'h08;
   localparam logic [4:0] REG_STATUS   = 5'h0C;
   localparam logic [4:0] REG_IRQ_STAT = 5'h10;
   localparam logic [4:0] REG_IRQ_MASK = 5'h14;

endpackage

// File: rtl/clk_gate_chan.sv
// clk_gate_chan: one clock-gate channel FSM with settle and idle-timeout counters
module clk_gate_chan
   import clk_gate_sched_pkg::*;
#(
   parameter int SETTLE = 4,
   parameter int TMO_W  = 16
) (
   input  logic             clock,
   input  logic             nRst,
   input  logic             want,
   input  logic             busy,
   input  logic             auto_gate,
   input  logic [TMO_W-1:0] timeout,
   output logic             clk_en,
   output logic             clk_rdy,
   output logic             gated_off
);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   ch_state_t        state, state_d;
   logic [SW-1:0]    settle_cnt;
   logic [TMO_W-1:0] idle_cnt;
   logic             keep, en_d, rdy_d;

   assign keep = want | busy;

   // State, counters and glitch-free registered outputs
   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         state      <= OFF;
         settle_cnt <= '0;
         idle_cnt   <= '0;
         clk_en     <= 1'b0;
         clk_rdy    <= 1'b0;
      end else begin
         state   <= state_d;
         clk_en  <= en_d;
         clk_rdy <= rdy_d;
         if (state == OFF)
            settle_cnt <= SW'(SETTLE - 1);
         else if (state == WAKE && settle_cnt != '0)
            settle_cnt <= settle_cnt - 1'b1;
         if (state != IDLE)
            idle_cnt <= timeout;
         else if (idle_cnt != '0)
            idle_cnt <= idle_cnt - 1'b1;
      end
   end

   // Next state; keep always wins over idle expiry so a busy peripheral is never gated
   always_comb begin
      state_d = state;
      case (state)
         OFF:     if (want) state_d = WAKE;
         WAKE:    if (settle_cnt == '0) state_d = ON;
         ON:      if (!keep) state_d = auto_gate ? IDLE : OFF;
         IDLE:    if (keep) state_d = ON; else if (idle_cnt == '0) state_d = OFF;
         default: state_d = OFF;
      endcase
   end

   // Output decode of the next state, plus the auto-gate event pulse
   always_comb begin
      en_d      = state_d != OFF;
      rdy_d     = state_d == ON || state_d == IDLE;
      gated_off = state == IDLE && state_d == OFF;
   end

endmodule

// File: rtl/clk_gate_sched.sv
// clk_gate_sched: bus-programmable clock-enable scheduler for N_CH gated peripheral clocks
// Optional IRQ_STAT/IRQ_MASK registers and irq output are enabled by CLK_GATE_SCHED_IRQ_EN
module clk_gate_sched
   import clk_gate_sched_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int SETTLE  = 4,
   parameter int TMO_W   = 16,
   parameter int DEF_TMO = 1000
) (
   input  logic            clock,
   input  logic            nRst,
   input  logic            HSEL,
   input  logic [31:0]     HADDR,
   input  logic            HWRITE,
   input  logic [31:0]     HWDATA,
   output logic [31:0]     HRDATA,
   input  logic [N_CH-1:0] periph_req,
   input  logic [N_CH-1:0] periph_busy,
   output logic [N_CH-1:0] clk_en,
   output logic [N_CH-1:0] clk_rdy,
   output logic            irq
);
   logic [N_CH-1:0]  swen, auto_en, want, gated_off;
   logic [TMO_W-1:0] tmo;
   logic [4:0]       sel;
   logic             wr, unused_bits;

   assign sel         = {HADDR[4:2], 2'b00};
   assign wr          = HSEL && HWRITE;
   assign want        = swen | (auto_en & periph_req);
   assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HWDATA, gated_off};

   // Config register writes; STATUS is read-only so writes to it fall through
   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         swen    <= '0;
         auto_en <= '0;
         tmo     <= TMO_W'(DEF_TMO);
      end else if (wr) begin
         if (sel == REG_SWEN) swen <= HWDATA[N_CH-1:0];
         if (sel == REG_AUTO) auto_en <= HWDATA[N_CH-1:0];
         if (sel == REG_TMO) tmo <= HWDATA[TMO_W-1:0];
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      clk_gate_chan #(.SETTLE(SETTLE), .TMO_W(TMO_W)) u_chan (
         .clock     (clock),
         .nRst      (nRst),
         .want      (want[i]),
         .busy      (periph_busy[i]),
         .auto_gate (auto_en[i]),
         .timeout   (tmo),
         .clk_en    (clk_en[i]),
         .clk_rdy   (clk_rdy[i]),
         .gated_off (gated_off[i])
      );
   end

`ifdef CLK_GATE_SCHED_IRQ_EN
   logic [N_CH-1:0] irq_stat, irq_mask, stat_d, mask_d;

   // Next IRQ state: W1C clear, with a same-cycle auto-gate event winning over the clear
   always_comb begin
      stat_d = (irq_stat & ~((wr && sel == REG_IRQ_STAT) ? HWDATA[N_CH-1:0] : {N_CH{1'b0}})) | gated_off;
      mask_d = (wr && sel == REG_IRQ_MASK) ? HWDATA[N_CH-1:0] : irq_mask;
   end

   // IRQ registers; irq is registered from next values so it tracks status on the same edge
   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         irq_stat <= '0;
         irq_mask <= '0;
         irq      <= 1'b0;
      end else begin
         irq_stat <= stat_d;
         irq_mask <= mask_d;
         irq      <= |(stat_d & mask_d);
      end
   end
`else
   assign irq = 1'b0;
`endif

   // Combinational read mux; unmapped offsets and unused bits read 0
   always_comb begin
      HRDATA = '0;
      if (HSEL && !HWRITE) begin
         case (sel)
            REG_SWEN:   HRDATA[N_CH-1:0] = swen;
            REG_AUTO:   HRDATA[N_CH-1:0] = auto_en;
            REG_TMO:    HRDATA[TMO_W-1:0] = tmo;
            REG_STATUS: begin
               HRDATA[N_CH-1:0]   = clk_en;
               HRDATA[N_CH+7:8]   = clk_rdy;
            end
`ifdef CLK_GATE_SCHED_IRQ_EN
            REG_IRQ_STAT: HRDATA[N_CH-1:0] = irq_stat;
            REG_IRQ_MASK: HRDATA[N_CH-1:0] = irq_mask;
`endif
            default:    HRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_gate_sched.sv
// tb_clk_gate_sched: directed scoreboard bench for clk_gate_sched (default N_CH=4, SETTLE=4)
module tb_clk_gate_sched;
   localparam int N_CH = 4;
`ifdef CLK_GATE_SCHED_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic            clock = 1'b0;
   logic            nRst = 1'b0;
   logic            HSEL = 1'b0;
   logic            HWRITE = 1'b0;
   logic [31:0]     HADDR = '0;
   logic [31:0]     HWDATA = '0;
   logic [31:0]     HRDATA;
   logic [N_CH-1:0] periph_req = '0;
   logic [N_CH-1:0] periph_busy = '0;
   logic [N_CH-1:0] clk_en, clk_rdy;
   logic            irq;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   clk_gate_sched #(.N_CH(N_CH), .SETTLE(4), .TMO_W(16), .DEF_TMO(1000)) dut (
      .clock       (clock),
      .nRst        (nRst),
      .HSEL        (HSEL),
      .HADDR       (HADDR),
      .HWRITE      (HWRITE),
      .HWDATA      (HWDATA),
      .HRDATA      (HRDATA),
      .periph_req  (periph_req),
      .periph_busy (periph_busy),
      .clk_en      (clk_en),
      .clk_rdy     (clk_rdy),
      .irq         (irq)
   );

   task automatic push(input string tag, input logic [31:0] val);
      sb.push_back('{tag: tag, val: val});
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      HSEL = 1'b1; HWRITE = 1'b1; HADDR = a; HWDATA = d;
      @(negedge clock);
      HSEL = 1'b0; HWRITE = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
      @(negedge clock);
      HSEL = 1'b1; HWRITE = 1'b0; HADDR = a;
      push(tag, e);
      #1 check(HRDATA);
      HSEL = 1'b0;
   endtask

   // Pulse periph_req[ch] for one cycle; returns on the negedge after the wake edge
   task automatic pulse_req(input int ch);
      @(negedge clock);
      periph_req[ch] = 1'b1;
      @(negedge clock);
      periph_req[ch] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] seq[$];
      // reset state
      repeat (3) @(negedge clock);
      nRst = 1'b1;
      push("rst_clk_en", 32'h0); check(32'(clk_en));
      push("rst_clk_rdy", 32'h0); check(32'(clk_rdy));
      push("rst_irq", 32'h0); check(32'(irq));
      rd("rst_tmo", 32'h08, 32'd1000);
      rd("rst_swen", 32'h00, 32'h0);
      rd("rst_auto", 32'h04, 32'h0);
      rd("rst_status", 32'h0C, 32'h0);
      rd("rst_irq_stat", 32'h10, 32'h0);

      // software wake of channel 0: enable one edge after write, ready SETTLE edges later
      wr(32'h00, 32'h1);
      seq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
      foreach (seq[k]) push("swen_wake", 32'(seq[k]));
      foreach (seq[k]) begin
         if (k > 0) @(negedge clock);
         check(32'({clk_rdy[0], clk_en[0]}));
      end
      rd("status_ch0", 32'h0C, 32'h0101);
      wr(32'h0C, 32'hFFFF_FFFF);
      rd("status_ro", 32'h0C, 32'h0101);
      rd("swen_after_status_wr", 32'h00, 32'h1);
      HADDR = 32'h08;
      #1 push("hrdata_idle_bus", 32'h0);
      check(HRDATA);
      rd("unmapped_18", 32'h18, 32'h0);

      // auto wake of channel 1 and auto-gate after TIMEOUT=5
      wr(32'h04, 32'h2);
      wr(32'h08, 32'd5);
      wr(32'h14, 32'h2);
      rd("auto_rb", 32'h04, 32'h2);
      rd("tmo_rb", 32'h08, 32'd5);
      rd("irq_mask_rb", 32'h14, IRQ ? 32'h2 : 32'h0);
      pulse_req(1);
      seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11,
              2'b11, 2'b11, 2'b11, 2'b00};
      foreach (seq[k]) push("auto_gate_ch1", 32'(seq[k]));
      foreach (seq[k]) begin
         if (k > 0) @(negedge clock);
         check(32'({clk_rdy[1], clk_en[1]}));
      end
      push("irq_after_gate", IRQ ? 32'h1 : 32'h0); check(32'(irq));
      rd("irq_stat_after_gate", 32'h10, IRQ ? 32'h2 : 32'h0);
      wr(32'h10, 32'h2);
      push("irq_after_w1c", 32'h0); check(32'(irq));
      rd("irq_stat_after_w1c", 32'h10, 32'h0);

      // re-request while idle with counter at 1: back to ON, then full timeout restarts
      pulse_req(1);
      seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
              2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
      foreach (seq[k]) push("idle_rekeep_ch1", 32'(seq[k]));
      foreach (seq[k]) begin
         if (k > 0) @(negedge clock);
         periph_req[1] = (k >= 9 && k < 12);
         check(32'({clk_rdy[1], clk_en[1]}));
      end

      // SWEN cleared while busy: channel 0 held on until busy drops
      @(negedge clock);
      periph_busy[0] = 1'b1;
      wr(32'h00, 32'h0);
      for (int k = 0; k < 12; k++) push("busy_hold_ch0", k < 11 ? 32'h3 : 32'h0);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clock);
         if (k == 10) periph_busy[0] = 1'b0;
         check(32'({clk_rdy[0], clk_en[0]}));
      end

      // TIMEOUT=0 on channel 2: leaves IDLE on the cycle after entry
      wr(32'h04, 32'h4);
      wr(32'h08, 32'd0);
      pulse_req(2);
      seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
      foreach (seq[k]) push("tmo0_ch2", 32'(seq[k]));
      foreach (seq[k]) begin
         if (k > 0) @(negedge clock);
         check(32'({clk_rdy[2], clk_en[2]}));
      end
      rd("status_all_off", 32'h0C, 32'h0);
      push("irq_final", IRQ ? 32'h1 : 32'h0); check(32'(irq));

      // asynchronous reset mid-wake drops everything at once
      wr(32'h00, 32'hF);
      repeat (2) @(negedge clock);
      #2 nRst = 1'b0;
      #1 push("async_rst_en", 32'h0);
      check(32'(clk_en));
      nRst = 1'b1;
      rd("async_rst_swen", 32'h00, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
